// File: rtl/wb_arb_pkg.sv
// Shared types for the two-host Wishbone arbiter in front of the Marmot slave port.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StErr
  } arb_state_e;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  typedef struct packed {
    logic        ack;
    logic [31:0] dat;
  } wb_rsp_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  function automatic logic wants_bus(input wb_req_t req);
    return req.cyc & req.stb;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// No-ack watchdog: counts stalled strobe cycles, pulses expire, keeps a sticky flag.
module wb_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ack,
  input  logic restart,
  input  logic clr,
  output logic expire,
  output logic irq
);

  localparam logic [15:0] LastCount = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count_q, count_d;
  logic        irq_q, irq_d;

  always_comb begin
    expire  = active & ~ack & (count_q == LastCount);
    count_d = count_q;
    if (restart || !active || ack) begin
      count_d = '0;
    end else if (!expire) begin
      count_d = count_q + 16'd1;
    end
    // A new expiry wins over a clear arriving in the same cycle.
    irq_d = irq_q;
    if (expire) begin
      irq_d = 1'b1;
    end else if (clr) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      irq_q   <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: rtl/wb_host_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between the management SoC (host 0)
// and a logic-analyzer debug master (host 1), with bus locking and a no-ack watchdog.
module wb_host_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,

  output logic [1:0]  grant_o,
  output logic        timeout_irq_o,
  input  logic        timeout_clr_i
);

  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;  // index of the previous owner

  wb_req_t req0, req1, owner_req, bus;
  wb_rsp_t rsp0, rsp1, owner_rsp;
  logic    owner_idx;
  logic    expire;

  assign req0 = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i, sel: m0_sel_i,
                  adr: m0_adr_i, dat: m0_dat_i};
  assign req1 = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i, sel: m1_sel_i,
                  adr: m1_adr_i, dat: m1_dat_i};

  assign owner_idx = grant_q[1];
  assign owner_req = owner_idx ? req1 : req0;

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .active (bus.cyc & bus.stb),
    .ack    (s_ack_i),
    .restart(state_q != StBusy),
    .clr    (timeout_clr_i),
    .expire (expire),
    .irq    (timeout_irq_o)
  );

  // Bus and response steering; everything is zero outside an active ownership.
  always_comb begin
    bus       = '0;
    owner_rsp = '0;
    unique case (state_q)
      StBusy: begin
        bus       = owner_req;
        owner_rsp = '{ack: s_ack_i, dat: s_dat_i};
      end
      StErr: begin
        owner_rsp = '{ack: 1'b1, dat: owner_req.we ? 32'h0 : ERR_DATA};
      end
      default: ;
    endcase
    rsp0 = grant_q[0] ? owner_rsp : '0;
    rsp1 = grant_q[1] ? owner_rsp : '0;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (wants_bus(req0) && wants_bus(req1)) begin
          grant_d = last_q ? 2'b01 : 2'b10;
          state_d = StBusy;
        end else if (wants_bus(req0)) begin
          grant_d = 2'b01;
          state_d = StBusy;
        end else if (wants_bus(req1)) begin
          grant_d = 2'b10;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // Ownership is held for as long as the owner keeps cyc asserted.
        if (!owner_req.cyc) begin
          state_d = StIdle;
          grant_d = 2'b00;
          last_d  = owner_idx;
        end else if (expire) begin
          state_d = StErr;
        end
      end
      StErr: begin
        state_d = StIdle;
        grant_d = 2'b00;
        last_d  = owner_idx;
      end
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign s_cyc_o  = bus.cyc;
  assign s_stb_o  = bus.stb;
  assign s_we_o   = bus.we;
  assign s_sel_o  = bus.sel;
  assign s_adr_o  = bus.adr;
  assign s_dat_o  = bus.dat;

  assign m0_ack_o = rsp0.ack;
  assign m0_dat_o = rsp0.dat;
  assign m1_ack_o = rsp1.ack;
  assign m1_dat_o = rsp1.dat;

  assign grant_o  = grant_q;

endmodule

// File: doc/wb_host_arbiter.md
Name: wb_host_arbiter

Overview:
- Shares the single Wishbone slave port of the Marmot user-project core between two hosts.
- Host 0 is the Caravel management SoC (wbs_* bus). Host 1 is a debug master driven from logic-analyzer probes.
- Sits in user_project_wrapper between the wrapper pins and Marmot. Provides round-robin arbitration, bus locking for the duration of each cycle, and a no-ack watchdog that terminates hung transfers with an error word.

Parameters:
- TIMEOUT_CYCLES, 256, cycles s_stb_o may stay high without s_ack_i before the transfer is force-terminated (legal range 2..65535).
- ERR_DATA, 32'hDEAD_BEEF, read data returned to the host on a timed-out transfer.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  host 0 Wishbone controls.
- m0_sel_i  in  4  host 0 byte selects.
- m0_adr_i, m0_dat_i  in  32 each  host 0 address and write data.
- m0_dat_o  out  32  host 0 read data.
- m0_ack_o  out  1  host 0 acknowledge.
- m1_*  same set and widths as m0_*, for host 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave.
- s_sel_o  out  4  to slave.
- s_adr_o, s_dat_o  out  32 each  to slave.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave acknowledge.
- grant_o  out  2  one-hot current owner; 00 when idle.
- timeout_irq_o  out  1  sticky watchdog flag.
- timeout_clr_i  in  1  clears timeout_irq_o.

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant_o=00, last_grant=host 1 (so host 0 wins first tie), watchdog=0, timeout_irq_o=0.
  - All s_* outputs are 0. Both m*_ack_o are 0 and both m*_dat_o are 0.
- FSM states: IDLE, BUSY, ERR.
- IDLE:
  - Requester n = mn_cyc_i & mn_stb_i.
  - One requester: grant it.
  - Both: grant the host not equal to last_grant.
  - Grant is registered, so arbitration latency is 1 cycle. The slave first sees stb the cycle after the request.
  - No requester: stay in IDLE.
- BUSY:
  - s_cyc/stb/we/sel/adr/dat are a combinational mux of the granted host's inputs.
  - The granted host's m_ack_o = s_ack_i and m_dat_o = s_dat_i, combinationally.
  - The non-granted host always sees ack=0 and dat=0; its stb is held off until it is granted.
  - The bus stays locked while the granted host's cyc_i=1, so back-to-back and block transfers are not interrupted.
  - When the granted host's cyc_i=0: go to IDLE, last_grant is set to the owner, grant_o=00. Re-arbitration occurs in that IDLE cycle, so there is one dead cycle between owners.
- Watchdog:
  - Counts cycles with s_stb_o=1 & s_ack_i=0. It is cleared on s_ack_i, on entry to BUSY, and whenever s_stb_o=0.
  - When the count reaches TIMEOUT_CYCLES-1 with no ack in that cycle, the FSM goes to ERR.
- ERR (exactly 1 cycle):
  - s_cyc_o=s_stb_o=0.
  - Owner sees m_ack_o=1 and m_dat_o=ERR_DATA (for a write, the ack alone is returned).
  - timeout_irq_o sets.
  - Next state is IDLE, with last_grant updated to the owner.
- An s_ack_i that arrives in the cycle the watchdog expires counts as a normal completion; no ERR.
- A stray s_ack_i in IDLE or ERR is ignored.
- timeout_irq_o: set has priority over timeout_clr_i in the same cycle. Otherwise clr=1 clears it.
- The owner dropping cyc mid-transfer, before ack, is legal: return to IDLE and clear the watchdog.
- Reset asserted mid-transfer: all outputs drop to reset values immediately (asynchronous). No ack is produced.

Decomposition:
- Package wb_arb_pkg holds:
  - the state enum (IDLE/BUSY/ERR);
  - the wb_req_t struct (cyc, stb, we, sel[3:0], adr[31:0], dat[31:0]);
  - the wb_rsp_t struct (ack, dat[31:0]);
  - ERR_DATA default.
- One sub-module, wb_arb_watchdog: counter, expiry pulse, sticky flag and clear. It keeps the timeout logic separately verifiable. The mux and FSM stay in the top.

Test Plan:
- Host 0 single read with ack 2 cycles after stb, s_dat_i=32'h1234_5678:
  - grant_o=01 one cycle after request;
  - m0_ack_o=1 with m0_dat_o=32'h1234_5678;
  - grant_o returns to 00 after cyc drops.
- Both hosts request in the same cycle out of reset:
  - host 0 is granted first;
  - after its cyc drops there is 1 IDLE cycle, then host 1 is granted.
  - Repeated simultaneous requests alternate 0,1,0,1.
- Host 1 holds cyc across 4 back-to-back writes while host 0 requests:
  - host 0 sees no ack and no s_stb_o of its own until host 1's cyc drops.
- Slave never acks, TIMEOUT_CYCLES=8:
  - after 8 stb cycles, one ERR cycle gives m0_ack_o=1 with m0_dat_o=32'hDEAD_BEEF;
  - timeout_irq_o=1 and s_cyc_o=0.
- Slave acks on exactly the expiry cycle: normal completion with slave data, timeout_irq_o stays 0.
- timeout_clr_i pulses in the same cycle as a new expiry: flag stays 1. A clr one cycle later takes it to 0.
- wb_rst_i asserted mid-BUSY: all s_* and m*_ack_o go to 0 without waiting for a clock edge. After release, host 0 wins the first tie.
